// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer.
//   packer_state_t : packer FSM encoding
//   slice_width()  : bits delivered per FIFO read (PAR_READ*DATA_WIDTH)
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PRESENT
    } packer_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PAR_READ   = 1;

    function automatic int slice_width(input int dw, input int pr);
        return dw * pr;
    endfunction

endpackage

// File: rtl/fifo_beat_packer_if.sv
// Bus between the FIFO read port / compute stage and the beat packer.
//   master : environment side (drives start, FIFO read data, out_ready)
//   slave  : packer side (drives fifo_read_enable, packed output, status)
interface fifo_beat_packer_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_READ   = 1,
    parameter int BEATS      = 4,
    parameter int CNT_WIDTH  = 8
);
    localparam int SW = slice_width(DATA_WIDTH, PAR_READ);

    logic                  start;
    logic [CNT_WIDTH-1:0]  num_packets;
    logic                  fifo_valid;
    logic [SW-1:0]         fifo_dout;
    logic                  fifo_read_enable;
    logic                  out_valid;
    logic                  out_ready;
    logic [BEATS*SW-1:0]   out_data;
    logic                  busy;
    logic                  done;

    modport master (
        output start, num_packets, fifo_valid, fifo_dout, out_ready,
        input  fifo_read_enable, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, num_packets, fifo_valid, fifo_dout, out_ready,
        output fifo_read_enable, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/fifo_beat_packer_beat_counter.sv
// Beat counter with synchronous clear and increment.
//   i_clr : return to 0 (wins over i_inc)
//   i_inc : advance by one
//   o_cnt : current count
//   o_tc  : count equals TERM
module beat_counter #(
    parameter int WIDTH = 2,
    parameter int TERM  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + WIDTH'(1);
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == WIDTH'(TERM));
endmodule

// File: rtl/fifo_beat_packer.sv
// Drains num_packets packets of BEATS FIFO reads each, packs every packet
// into one wide word (beat 0 in the LSBs) and hands it downstream on
// valid/ready. Sole owner of the FIFO read side.
//   clk, rst : clock, async active-high reset
//   bus      : slave view of fifo_beat_packer_if
module fifo_beat_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_READ   = 1,
    parameter int BEATS      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_beat_packer_if.slave    bus
);
    localparam int SW  = slice_width(DATA_WIDTH, PAR_READ);
    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;

    packer_state_t          r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_pkt_left;
    logic [BEATS*SW-1:0]    r_data;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_dec;
    logic                   w_beat_clr;
    logic                   w_beat_tc;
    logic [BCW-1:0]         w_beat;

    beat_counter #(
        .WIDTH (BCW),
        .TERM  (BEATS - 1)
    ) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_beat_clr),
        .i_inc (w_pop),
        .o_cnt (w_beat),
        .o_tc  (w_beat_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_beat_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_packets != '0) begin
                        w_state_nxt = COLLECT;
                        w_load      = 1'b1;
                        w_beat_clr  = 1'b1;
                    end else begin
                        // Empty request: acknowledge without touching the FIFO.
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            COLLECT: begin
                // Mealy pop: never asserted against an empty FIFO.
                w_pop = bus.fifo_valid;
                if (bus.fifo_valid && w_beat_tc) begin
                    w_state_nxt = PRESENT;
                    w_beat_clr  = 1'b1;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    w_dec = 1'b1;
                    if (r_pkt_left == CNT_WIDTH'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = COLLECT;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_pkt_left <= '0;
        else if (w_load) r_pkt_left <= bus.num_packets;
        else if (w_dec)  r_pkt_left <= r_pkt_left - CNT_WIDTH'(1);
    end

    // Each pop lands in the slice selected by the beat counter; older slices
    // keep their value until the next packet overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                if (w_pop && (w_beat == BCW'(b)))
                    r_data[b*SW +: SW] <= bus.fifo_dout;
            end
        end
    end

    assign bus.fifo_read_enable = w_pop;
    assign bus.out_valid        = (r_state == PRESENT);
    assign bus.out_data         = r_data;
    assign bus.busy             = (r_state != IDLE);
    assign bus.done             = r_done;
endmodule

// File: tb/tb_fifo_beat_packer.sv
module tb_fifo_beat_packer;
    localparam int DW = 8;
    localparam int PR = 1;
    localparam int BT = 4;
    localparam int CW = 8;

    logic clk;
    logic rst;

    fifo_beat_packer_if #(.DATA_WIDTH(DW), .PAR_READ(PR), .BEATS(BT), .CNT_WIDTH(CW)) bus ();

    fifo_beat_packer #(.DATA_WIDTH(DW), .PAR_READ(PR), .BEATS(BT), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: words in q, optional per-cycle valid gating in gate_q.
    logic [DW-1:0] q[$];
    bit            gate_q[$];
    int            pops     = 0;
    int            bad_pops = 0;
    int            done_cnt = 0;

    always @(posedge clk) begin
        bit g;
        if (bus.fifo_read_enable) begin
            pops++;
            if (!bus.fifo_valid) bad_pops++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (bus.done) done_cnt++;
        #1;
        g = 1'b1;
        if (gate_q.size() > 0) g = gate_q.pop_front();
        bus.fifo_valid = g && (q.size() > 0);
        bus.fifo_dout  = (q.size() > 0) ? q[0] : '0;
    end

    task automatic pulse_start(input logic [CW-1:0] n);
        bus.start       = 1'b1;
        bus.num_packets = n;
        @(negedge clk);
        bus.start       = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < lim);
        if (!bus.out_valid) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int p0;
        int d0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.num_packets = '0;
        bus.out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_fre",   bus.fifo_read_enable, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic single packet
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.out_ready = 1'b1;
        p0 = pops;
        pulse_start(1);
        chk("basic_busy", bus.busy, 1);
        chk("basic_fre",  bus.fifo_read_enable, 1);
        wait_valid(20, n);
        chk("basic_lat",  n, 4);
        chk("basic_data", bus.out_data, 32'h44332211);
        chk("basic_pops", pops - p0, 4);
        @(negedge clk);
        chk("basic_done",  bus.done, 1);
        chk("basic_idle",  bus.busy, 0);
        chk("basic_vlow",  bus.out_valid, 0);
        @(negedge clk);
        chk("basic_done1", bus.done, 0);

        // FIFO bubbles
        q = '{8'ha1, 8'hb2, 8'hc3, 8'hd4};
        gate_q = '{1, 0, 0, 1, 1, 0, 1};
        p0 = pops;
        pulse_start(1);
        @(negedge clk);
        chk("bub_fre_off", bus.fifo_read_enable, 0);
        wait_valid(20, n);
        chk("bub_lat",  n, 6);
        chk("bub_data", bus.out_data, 32'hd4c3b2a1);
        chk("bub_pops", pops - p0, 4);
        repeat (2) @(negedge clk);

        // Backpressure
        q = '{8'ha0, 8'ha1, 8'ha2, 8'ha3};
        bus.out_ready = 1'b0;
        pulse_start(1);
        wait_valid(20, n);
        chk("bp_lat", n, 4);
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data",  bus.out_data, 32'ha3a2a1a0);
            chk("bp_fre",   bus.fifo_read_enable, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_done", bus.done, 1);
        @(negedge clk);

        // Multi-packet
        q.delete();
        for (int i = 1; i <= 12; i++) q.push_back(DW'(i));
        p0 = pops;
        d0 = done_cnt;
        pulse_start(3);
        wait_valid(20, n);
        chk("mp0_lat",  n, 4);
        chk("mp0_data", bus.out_data, 32'h04030201);
        chk("mp0_busy", bus.busy, 1);
        wait_valid(20, n);
        chk("mp1_lat",  n, 5);
        chk("mp1_data", bus.out_data, 32'h08070605);
        chk("mp1_busy", bus.busy, 1);
        chk("mp1_done", bus.done, 0);
        wait_valid(20, n);
        chk("mp2_lat",  n, 5);
        chk("mp2_data", bus.out_data, 32'h0c0b0a09);
        @(negedge clk);
        chk("mp_done", bus.done, 1);
        chk("mp_idle", bus.busy, 0);
        repeat (2) @(negedge clk);
        chk("mp_done_cnt", done_cnt - d0, 1);
        chk("mp_pops",     pops - p0, 12);

        // num_packets = 0
        q = '{8'h90, 8'h91, 8'h92, 8'h93};
        p0 = pops;
        pulse_start(0);
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        @(negedge clk);
        chk("zero_done1", bus.done, 0);
        chk("zero_pops",  pops - p0, 0);

        // start during COLLECT ignored
        pulse_start(1);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.num_packets = 5;
        @(negedge clk);
        bus.start       = 1'b0;
        wait_valid(20, n);
        chk("ign_lat",  n, 2);
        chk("ign_data", bus.out_data, 32'h93929190);
        @(negedge clk);
        chk("ign_done", bus.done, 1);
        chk("ign_busy", bus.busy, 0);
        @(negedge clk);
        chk("ign_busy1", bus.busy, 0);

        // Reset after 2 pops
        q = '{8'h55, 8'h66, 8'h77, 8'h88};
        p0 = pops;
        pulse_start(1);
        @(negedge clk);
        @(negedge clk);
        chk("rr_pops", pops - p0, 2);
        rst = 1'b1;
        #1;
        chk("rr_fre",   bus.fifo_read_enable, 0);
        chk("rr_valid", bus.out_valid, 0);
        chk("rr_data",  bus.out_data, 0);
        chk("rr_busy",  bus.busy, 0);
        chk("rr_done",  bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        q = '{8'h71, 8'h72, 8'h73, 8'h74};
        @(negedge clk);
        p0 = pops;
        pulse_start(1);
        wait_valid(20, n);
        chk("rr_lat",   n, 4);
        chk("rr_fresh", bus.out_data, 32'h74737271);
        chk("rr_pops2", pops - p0, 4);
        repeat (2) @(negedge clk);

        chk("no_empty_pop", bad_pops, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
